// File: rtl/serial_adder.sv
// Bit-serial adder: one full-adder cell plus a registered carry, LSB first.
// Takes WIDTH cycles per addition and returns the result through a start/done handshake.
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  // state | meaning
  // IDLE  | waiting for start; operands captured on the accepting edge
  // RUN   | one bit pair added per edge, LSB first
  // DONE  | sum/cout just updated; done high for this single cycle
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           state;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] s_sr;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic             s_bit;
  logic             c_bit;

  // Full-adder cell, fed only from registers.
  assign s_bit = a_sr[0] ^ b_sr[0] ^ carry;
  assign c_bit = (a_sr[0] & b_sr[0]) | (a_sr[0] & carry) | (b_sr[0] & carry);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
      sum   <= '0;
      cout  <= 1'b0;
      a_sr  <= '0;
      b_sr  <= '0;
      s_sr  <= '0;
      carry <= 1'b0;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            a_sr  <= a;
            b_sr  <= b;
            carry <= cin;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= RUN;
          end
        end
        RUN: begin
          a_sr  <= a_sr >> 1;
          b_sr  <= b_sr >> 1;
          s_sr  <= {s_bit, s_sr[WIDTH-1:1]};
          carry <= c_bit;
          cnt   <= cnt + 1'b1;
          if (cnt == LAST) begin
            sum   <= {s_bit, s_sr[WIDTH-1:1]};
            cout  <= c_bit;
            done  <= 1'b1;
            state <= DONE;
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
// Directed and random checks of serial_adder at WIDTH=8 and WIDTH=16
// against a plain a+b+cin reference.
module tb_serial_adder;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        start8 = 1'b0, cin8 = 1'b0;
  logic [7:0]  a8 = '0, b8 = '0;
  logic        busy8, done8, cout8;
  logic [7:0]  sum8;

  logic        start16 = 1'b0, cin16 = 1'b0;
  logic [15:0] a16 = '0, b16 = '0;
  logic        busy16, done16, cout16;
  logic [15:0] sum16;

  int tests = 0;
  int fails = 0;

  serial_adder #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8), .cin(cin8),
    .busy(busy8), .done(done8), .sum(sum8), .cout(cout8)
  );

  serial_adder #(.WIDTH(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .start(start16), .a(a16), .b(b16), .cin(cin16),
    .busy(busy16), .done(done16), .sum(sum16), .cout(cout16)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called at a falling edge; the operation is accepted on the next rising edge.
  task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic c, input string tag);
    logic [8:0] ref_v;
    int n;
    ref_v = {1'b0, a} + {1'b0, b} + {8'd0, c};
    a8 = a; b8 = b; cin8 = c; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    n = 0;
    while (!done8 && n < 40) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_lat"}, n, 8);
    check({tag, "_res"}, {cout8, sum8}, ref_v);
    @(negedge clk);
    check({tag, "_end"}, {busy8, done8}, 2'b00);
  endtask

  task automatic op16(input logic [15:0] a, input logic [15:0] b, input logic c, input string tag);
    logic [16:0] ref_v;
    int n;
    ref_v = {1'b0, a} + {1'b0, b} + {16'd0, c};
    a16 = a; b16 = b; cin16 = c; start16 = 1'b1;
    @(negedge clk);
    start16 = 1'b0;
    n = 0;
    while (!done16 && n < 60) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_lat"}, n, 16);
    check({tag, "_res"}, {cout16, sum16}, ref_v);
    @(negedge clk);
    check({tag, "_end"}, {busy16, done16}, 2'b00);
  endtask

  initial begin
    int busy_cnt, done_at, done_cnt, k;
    int dt[3];
    logic [7:0] sum_at_done;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst8", {busy8, done8, cout8, sum8}, 0);
    check("rst16", {busy16, done16, cout16, sum16}, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // 1: basic add, latency and busy width
    a8 = 8'h3C; b8 = 8'h42; cin8 = 1'b0; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    busy_cnt = busy8 ? 1 : 0;
    done_at = -1;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      if (busy8) busy_cnt++;
      if (done8 && done_at < 0) done_at = i;
    end
    check("t1_busy_cycles", busy_cnt, 9);
    check("t1_done_edge", done_at, 8);
    check("t1_res", {cout8, sum8}, 9'h07E);

    // 2: overflow and corner operands
    op8(8'hFF, 8'h01, 1'b0, "t2_ff01");
    op8(8'hA5, 8'h5A, 1'b1, "t2_a55a");
    op8(8'h00, 8'h00, 1'b0, "t2_zero");

    // 3: start pulses while busy (RUN and DONE) are ignored
    a8 = 8'h10; b8 = 8'h20; cin8 = 1'b0; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0; a8 = 8'hFF; b8 = 8'hFF;
    done_cnt = 0;
    sum_at_done = 8'h00;
    for (int i = 1; i <= 20; i++) begin
      start8 = (i == 4 || i == 9);
      @(negedge clk);
      if (done8) begin
        done_cnt++;
        sum_at_done = sum8;
      end
      if (i == 15) check("t3_idle_after", busy8, 1'b0);
    end
    start8 = 1'b0;
    check("t3_done_count", done_cnt, 1);
    check("t3_sum", sum_at_done, 8'h30);
    check("t3_cout", cout8, 1'b0);

    // 4: inputs toggling during RUN do not disturb the result
    a8 = 8'h81; b8 = 8'h81; cin8 = 1'b0; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    for (int i = 1; i <= 9; i++) begin
      a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom);
      @(negedge clk);
    end
    check("t4_res", {cout8, sum8}, 9'h102);

    // 5: asynchronous reset mid-operation
    a8 = 8'h11; b8 = 8'h22; cin8 = 1'b0; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    repeat (4) @(negedge clk);
    check("t5_busy_before", busy8, 1'b1);
    #2 rst_n = 1'b0;
    #1 check("t5_async_clear", {busy8, done8, cout8, sum8}, 0);
    @(negedge clk);
    check("t5_held", {busy8, done8}, 2'b00);
    rst_n = 1'b1;
    @(negedge clk);
    op8(8'h01, 8'h01, 1'b0, "t5_after");

    // 6: start held high, back-to-back operations
    a8 = 8'h03; b8 = 8'h04; cin8 = 1'b0; start8 = 1'b1;
    k = 0;
    for (int i = 0; i < 60 && k < 3; i++) begin
      @(negedge clk);
      if (done8) begin
        dt[k] = i;
        k++;
      end
    end
    start8 = 1'b0;
    check("t6_done_pulses", k, 3);
    check("t6_gap1", dt[1] - dt[0], 10);
    check("t6_gap2", dt[2] - dt[1], 10);
    check("t6_res", {cout8, sum8}, 9'h007);
    repeat (2) @(negedge clk);

    // Random sweep, both widths
    for (int i = 0; i < 500; i++)
      op8(8'($urandom), 8'($urandom), 1'($urandom), "rnd8");
    for (int i = 0; i < 500; i++)
      op16(16'($urandom), 16'($urandom), 1'($urandom), "rnd16");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/serial_adder.md
Name: serial_adder

Overview:
Bit-serial adder of two WIDTH-bit unsigned operands, built around one full-adder bit cell plus a registered carry, LSB first.
- Trades the ripple chain for WIDTH clock cycles per addition.
- Sits as the sequential stage directly around the team's combinational full-adder cell: it feeds the cell one bit pair and the stored carry each cycle, and captures the cell's sum and carry-out.
- Result is returned through a start/done handshake.

Parameters:
WIDTH, 8, operand and sum width in bits (legal range 2..32).

Ports:
clk  input  1  system clock, rising-edge.
rst_n  input  1  asynchronous active-low reset.
start  input  1  request; sampled only while in IDLE.
a  input  WIDTH  operand A, captured on the accepting edge.
b  input  WIDTH  operand B, captured on the accepting edge.
cin  input  1  carry-in, captured on the accepting edge.
busy  output  1  high in RUN and DONE states.
done  output  1  one-cycle pulse when sum/cout are updated.
sum  output  WIDTH  registered result, low WIDTH bits of a+b+cin.
cout  output  1  registered carry-out, bit WIDTH of a+b+cin.

Behaviour:
- Clock and reset: single clock clk. rst_n asynchronous, active-low. All flops clear immediately on rst_n low. Release is synchronous to clk (external synchroniser).
- Reset values: state=IDLE, busy=0, done=0, sum=0, cout=0. Internal shift registers, carry flop and counter all 0.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - start=1 at an edge loads a_sr<=a, b_sr<=b, carry<=cin, cnt<=0, and moves to RUN.
  - start=0 stays in IDLE.
- RUN (one bit per edge):
  - s_bit = a_sr[0]^b_sr[0]^carry.
  - c_bit = (a_sr[0]&b_sr[0])|(a_sr[0]&carry)|(b_sr[0]&carry).
  - a_sr and b_sr shift right by 1; s_sr shifts right with s_bit entering the MSB; carry<=c_bit; cnt<=cnt+1.
  - On the edge where cnt==WIDTH-1: sum<={s_bit, s_sr[WIDTH-1:1]}, cout<=c_bit, move to DONE.
- DONE: done=1 for exactly this one cycle. The next edge returns to IDLE unconditionally.
- Latency:
  - Accepting edge E0.
  - sum/cout valid and done=1 after edge E_WIDTH.
  - done deasserts after E_WIDTH+1.
  - Throughput: one addition per WIDTH+2 cycles maximum.
- Counter width: clog2(WIDTH) bits minimum; must not wrap before the terminal compare.
- start while busy=1, including the DONE cycle, is ignored; no queuing. A start held high continuously is accepted again on the first edge in IDLE.
- a, b and cin are don't-care after the accepting edge; changing them mid-operation must not affect the result.
- sum/cout hold their last value until the next completion. They never show partial results.
- Overflow: the sum wraps modulo 2^WIDTH; the overflow bit is reported only on cout.
- Reset mid-operation: abort immediately to IDLE. sum/cout return to 0 and no done pulse is issued.
- Purely synchronous datapath; no combinational path from inputs to outputs.

Test Plan:
1. Reset, then start with WIDTH=8, a=8'h3C, b=8'h42, cin=0 -> done pulse 8 edges after accept; sum=8'h7E, cout=0; busy high for exactly 9 cycles.
2. a=8'hFF, b=8'h01, cin=0 -> sum=8'h00, cout=1. Then a=8'hA5, b=8'h5A, cin=1 -> sum=8'h00, cout=1. Then a=8'h00, b=8'h00, cin=0 -> sum=8'h00, cout=0.
3. Accept a=8'h10, b=8'h20; pulse start with a=8'hFF, b=8'hFF at RUN cycle 3 and again in the DONE cycle -> single done pulse, sum=8'h30, cout=0, no second operation.
4. Change a and b every cycle during RUN after accepting a=8'h81, b=8'h81 -> sum=8'h02, cout=1.
5. Drop rst_n at RUN cycle 4 of an operation -> busy, done, sum and cout go to 0 asynchronously. After release, a new start with a=8'h01, b=8'h01 completes normally with sum=8'h02.
6. Hold start=1 continuously across 3 operations -> done pulses spaced exactly 10 cycles apart. Random-operand sweep (1000 vectors, WIDTH=8 and WIDTH=16) matches the reference a+b+cin.
